// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: op encodings, FSM states,
// iteration counts and small op-decode helpers.
package div_pkg;

  localparam logic [3:0] DIV_OP_DIV   = 4'd0;
  localparam logic [3:0] DIV_OP_REM   = 4'd1;
  localparam logic [3:0] DIV_OP_DIVU  = 4'd2;
  localparam logic [3:0] DIV_OP_REMU  = 4'd3;
  localparam logic [3:0] DIV_OP_DIVW  = 4'd4;
  localparam logic [3:0] DIV_OP_REMW  = 4'd5;
  localparam logic [3:0] DIV_OP_DIVUW = 4'd6;
  localparam logic [3:0] DIV_OP_REMUW = 4'd7;

  localparam logic [6:0] ITER_64 = 7'd64;
  localparam logic [6:0] ITER_32 = 7'd32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

  // Encoding: bit3 unsupported, bit2 W form, bit1 unsigned, bit0 remainder.
  function automatic logic op_unsupported(input logic [3:0] op);
    return op[3];
  endfunction

  function automatic logic op_is_w(input logic [3:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_signed(input logic [3:0] op);
    return !op[1];
  endfunction

  function automatic logic op_is_rem(input logic [3:0] op);
    return op[0];
  endfunction

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem, quo} left by one,
// trial-subtract the divisor, keep the difference when it does not borrow.
module div_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    shifted = {rem, quo[W-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[W]) begin
      rem_next = diff[W-1:0];
      quo_next = {quo[W-2:0], 1'b1};
    end else begin
      rem_next = shifted[W-1:0];
      quo_next = {quo[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle RV64M divider (DIV/REM/DIVU/REMU and W forms), valid/ready on both sides.
// Optional macro DIV_ZERO_BYPASS_EN: divide-by-zero completes straight from IDLE.
module div_iter
  import div_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [3:0]      control,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_out
);

  div_state_e  state_q, state_d;
  logic [6:0]  count_q;
  logic [63:0] rem_q, quo_q, dvs_q, dividend_q, result_q;
  logic [3:0]  op_q;
  logic        q_neg_q, r_neg_q, dz_q, ovf_q;

  logic        accept;
  logic        is_w_in, sgn_in, dz_in, ovf_in, bypass_in;
  logic [63:0] a_ext, b_ext, a_mag, b_mag, bypass_res;
  logic [63:0] step_rem, step_quo;
  logic [63:0] q_val, r_val, fix_res;

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign result_out = result_q;
  assign accept     = in_valid && in_ready && !flush;

  // Operand decode in the accept cycle: extend W operands, take magnitudes.
  always_comb begin
    is_w_in = op_is_w(control);
    sgn_in  = op_is_signed(control);
    a_ext   = src1;
    b_ext   = src2;
    if (is_w_in) begin
      a_ext = sgn_in ? sext32(src1[31:0]) : {32'b0, src1[31:0]};
      b_ext = sgn_in ? sext32(src2[31:0]) : {32'b0, src2[31:0]};
    end
    a_mag  = (sgn_in && a_ext[63]) ? -a_ext : a_ext;
    b_mag  = (sgn_in && b_ext[63]) ? -b_ext : b_ext;
    dz_in  = (b_ext == '0);
    ovf_in = sgn_in && (b_ext == '1) &&
             (a_ext == (is_w_in ? sext32(32'h8000_0000) : {1'b1, 63'b0}));
    bypass_res = op_is_rem(control) ? a_ext : '1;
    if (is_w_in) bypass_res = sext32(bypass_res[31:0]);
  end

`ifdef DIV_ZERO_BYPASS_EN
  assign bypass_in = dz_in;
`else
  assign bypass_in = 1'b0;
`endif

  div_step #(.W(64)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Sign correction and special cases applied in FIX.
  always_comb begin
    q_val = q_neg_q ? -quo_q : quo_q;
    r_val = r_neg_q ? -rem_q : rem_q;
    if (dz_q) begin
      q_val = '1;
      r_val = dividend_q;
    end else if (ovf_q) begin
      q_val = dividend_q;
      r_val = '0;
    end
    fix_res = op_is_rem(op_q) ? r_val : q_val;
    if (op_is_w(op_q)) fix_res = sext32(fix_res[31:0]);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (op_unsupported(control) || bypass_in) ? DONE : CALC;
      CALC: if (count_q == 7'd1) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // NOTE: sequential state always uses <= so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept && op_unsupported(control)) result_q <= '0;
      else if (accept && bypass_in)          result_q <= bypass_res;
      else if (state_q == FIX)               result_q <= fix_res;
    end
  end

  // NOTE: datapath registers carry no reset; the FSM never reads them before
  // an accept has loaded them.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q       <= control;
      count_q    <= is_w_in ? ITER_32 : ITER_64;
      rem_q      <= '0;
      quo_q      <= is_w_in ? {a_mag[31:0], 32'b0} : a_mag;
      dvs_q      <= b_mag;
      dividend_q <= a_ext;
      q_neg_q    <= sgn_in && (a_ext[63] ^ b_ext[63]);
      r_neg_q    <= sgn_in && a_ext[63];
      dz_q       <= dz_in;
      ovf_q      <= ovf_in;
    end else if (state_q == CALC) begin
      rem_q   <= step_rem;
      quo_q   <= step_quo;
      count_q <= count_q - 7'd1;
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed vectors, random ops against an
// arithmetic reference, backpressure, flush, reset and back-to-back handshakes.
module tb_div_iter;

  localparam logic [63:0] ALL1  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
`ifdef DIV_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] src1, src2, result_out;
  logic [3:0]  control;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  div_iter #(.XLEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .src1       (src1),
    .src2       (src2),
    .control    (control),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_out (result_out)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // RISC-V M-extension semantics computed with plain arithmetic.
  function automatic logic [63:0] ref_div(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    longint      sa, sb;
    int          sa32, sb32;
    logic [31:0] a32, b32, r32;
    logic [63:0] r;
    sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
    r = '0; r32 = '0;
    case (op)
      4'd0: if (b == 0) r = ALL1; else if (a == MIN64 && b == ALL1) r = a; else r = 64'(sa / sb);
      4'd1: if (b == 0) r = a; else if (a == MIN64 && b == ALL1) r = '0; else r = 64'(sa % sb);
      4'd2: if (b == 0) r = ALL1; else r = a / b;
      4'd3: if (b == 0) r = a; else r = a % b;
      4'd4, 4'd5, 4'd6, 4'd7: begin
        if (op == 4'd4) begin
          if (b32 == 0) r32 = 32'hFFFF_FFFF;
          else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = a32;
          else r32 = 32'(sa32 / sb32);
        end else if (op == 4'd5) begin
          if (b32 == 0) r32 = a32;
          else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = '0;
          else r32 = 32'(sa32 % sb32);
        end else if (op == 4'd6) begin
          r32 = (b32 == 0) ? 32'hFFFF_FFFF : a32 / b32;
        end else begin
          r32 = (b32 == 0) ? a32 : a32 % b32;
        end
        r = {{32{r32[31]}}, r32};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [63:0] b);
    logic zero;
    zero = op[2] ? (b[31:0] == 32'd0) : (b == 64'd0);
    if (op[3]) return 1;
    if (BYPASS && zero) return 1;
    return op[2] ? 34 : 66;
  endfunction

  // Present an op and return one cycle after the accept edge; inputs are
  // scrambled afterwards to show they are not re-sampled.
  task automatic start_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          output bit ok);
    int waited = 0;
    control  = op;
    src1     = a;
    src2     = b;
    in_valid = 1'b1;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    ok = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    control  = 4'($urandom);
    src1     = {$urandom, $urandom};
    src2     = {$urandom, $urandom};
  endtask

  // lat = cycle index (accept cycle = 0) in which out_valid is first high, -1 on timeout.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b expected 1", in_ready);
    else n_pass++;
    n_checks++;
    if (result_out !== 64'd0) $display("FAIL reset result_out: got %h expected 0", result_out);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    vec_t        v[$];
    bit          ok;
    int          lat;
    logic [63:0] res;
    v.push_back('{4'd0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2});
    v.push_back('{4'd1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2});
    v.push_back('{4'd2, ALL1, 64'd0});
    v.push_back('{4'd3, ALL1, 64'd0});
    v.push_back('{4'd0, MIN64, ALL1});
    v.push_back('{4'd1, MIN64, ALL1});
    v.push_back('{4'd4, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF});
    v.push_back('{4'd6, 64'h0000_0000_FFFF_FFFE, 64'd1});
    v.push_back('{4'd5, 64'h1234_5678_8765_4321, 64'hFFFF_FFFF_0000_0000});
    v.push_back('{4'd7, 64'h0000_0000_9000_0000, 64'h0000_0000_0000_0007});
    foreach (v[i]) begin
      start_op(v[i].op, v[i].a, v[i].b, ok);
      wait_done(lat);
      res = result_out;
      take_result();
      n_checks++;
      if (res !== ref_div(v[i].op, v[i].a, v[i].b))
        $display("FAIL directed[%0d] result op=%0d: got %h expected %h", i, v[i].op, res,
                 ref_div(v[i].op, v[i].a, v[i].b));
      else n_pass++;
      n_checks++;
      if (lat != ref_lat(v[i].op, v[i].b))
        $display("FAIL directed[%0d] latency: got %0d expected %0d", i, lat,
                 ref_lat(v[i].op, v[i].b));
      else n_pass++;
    end
  endtask

  task automatic test_unsupported();
    logic [3:0] ops[2];
    bit          ok;
    int          lat;
    logic [63:0] res;
    ops[0] = 4'd9;
    ops[1] = 4'd15;
    foreach (ops[i]) begin
      start_op(ops[i], {$urandom, $urandom}, (i == 0) ? {$urandom, $urandom} : 64'd0, ok);
      wait_done(lat);
      res = result_out;
      take_result();
      n_checks++;
      if (res !== 64'd0) $display("FAIL unsupported result op=%0d: got %h expected 0", ops[i], res);
      else n_pass++;
      n_checks++;
      if (lat != 1) $display("FAIL unsupported latency op=%0d: got %0d expected 1", ops[i], lat);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    bit          ok, stable;
    int          lat;
    logic [63:0] a, b, r0;
    a = {$urandom, $urandom};
    b = {32'd0, $urandom} | 64'd1;
    start_op(4'd0, a, b, ok);
    wait_done(lat);
    r0 = result_out;
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (result_out !== r0 || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    n_checks++;
    if (!stable) $display("FAIL backpressure hold: got unstable output expected stable for 10 cycles");
    else n_pass++;
    n_checks++;
    if (r0 !== ref_div(4'd0, a, b))
      $display("FAIL backpressure result: got %h expected %h", r0, ref_div(4'd0, a, b));
    else n_pass++;
    take_result();
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL backpressure release in_ready: got %b expected 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_flush();
    bit          ok, saw_valid;
    int          lat;
    logic [63:0] res;
    start_op(4'd0, 64'd1000, 64'd7, ok);
    repeat (19) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL flush idle: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    else n_pass++;
    saw_valid = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    n_checks++;
    if (saw_valid) $display("FAIL flush no result: got out_valid=1 expected 0");
    else n_pass++;
    // in_valid during a flush cycle must not be accepted
    flush    = 1'b1;
    in_valid = 1'b1;
    control  = 4'd2;
    src1     = 64'd50;
    src2     = 64'd5;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL flush no accept: got in_ready=%b expected 1", in_ready);
    else n_pass++;
    start_op(4'd3, 64'd12345, 64'd100, ok);
    wait_done(lat);
    res = result_out;
    take_result();
    n_checks++;
    if (res !== 64'd45) $display("FAIL after flush result: got %h expected %h", res, 64'd45);
    else n_pass++;
    n_checks++;
    if (lat != 66) $display("FAIL after flush latency: got %0d expected 66", lat);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit          ok;
    int          lat1, lat2;
    logic [63:0] r1, r2;
    start_op(4'd4, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, ok);
    wait_done(lat1);
    r1 = result_out;
    out_ready = 1'b1;
    control   = 4'd1;
    src1      = 64'hFFFF_FFFF_FFFF_FF9C;
    src2      = 64'd7;
    in_valid  = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL b2b handshake in_ready: got %b expected 0", in_ready);
    else n_pass++;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL b2b idle: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    src1     = {$urandom, $urandom};
    src2     = {$urandom, $urandom};
    control  = 4'($urandom);
    wait_done(lat2);
    r2 = result_out;
    take_result();
    n_checks++;
    if (r1 !== 64'hFFFF_FFFF_FFFF_FFF2 || lat1 != 34)
      $display("FAIL b2b first: got %h lat %0d expected %h lat 34", r1, lat1, 64'hFFFF_FFFF_FFFF_FFF2);
    else n_pass++;
    n_checks++;
    if (r2 !== 64'hFFFF_FFFF_FFFF_FFFE || lat2 != 66)
      $display("FAIL b2b second: got %h lat %0d expected %h lat 66", r2, lat2, 64'hFFFF_FFFF_FFFF_FFFE);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok, saw_valid;
    start_op(4'd2, {$urandom, $urandom}, 64'd3, ok);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset mid-op: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    else n_pass++;
    saw_valid = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    n_checks++;
    if (saw_valid || result_out !== 64'd0)
      $display("FAIL reset mid-op quiet: got out_valid seen=%b result=%h expected 0/0", saw_valid,
               result_out);
    else n_pass++;
  endtask

  task automatic test_random();
    bit          ok;
    int          lat;
    logic [3:0]  op;
    logic [63:0] a, b, res;
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? (op[2] ? 64'h0000_0000_8000_0000 : MIN64)
                                       : {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = 64'd0;
        1: b = ALL1;
        2: b = 64'($urandom_range(1, 9));
        default: b = {$urandom, $urandom} >> $urandom_range(0, 40);
      endcase
      start_op(op, a, b, ok);
      wait_done(lat);
      res = result_out;
      take_result();
      n_checks++;
      if (res !== ref_div(op, a, b))
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h expected %h", n, op, a, b, res,
                 ref_div(op, a, b));
      else n_pass++;
      n_checks++;
      if (lat != ref_lat(op, b))
        $display("FAIL random[%0d] latency op=%0d: got %0d expected %0d", n, op, lat, ref_lat(op, b));
      else n_pass++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    control   = 4'd0;
    src1      = '0;
    src2      = '0;
    test_reset();
    test_directed();
    test_unsupported();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
